// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, Status/Cause bit positions, ExcCode values
// and the EXCEPT_* codes also used by the exception handler.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam logic [2:0] EXCEPT_NONE      = 3'd0;
    localparam logic [2:0] EXCEPT_INTERRUPT = 3'd1;
    localparam logic [2:0] EXCEPT_SYSCALL   = 3'd2;
    localparam logic [2:0] EXCEPT_RI        = 3'd3;
    localparam logic [2:0] EXCEPT_OVERFLOW  = 3'd4;
    localparam logic [2:0] EXCEPT_TRAP      = 3'd5;
    localparam logic [2:0] EXCEPT_ERET      = 3'd6;

    function automatic logic [4:0] excCodeOf(input logic [2:0] code);
        case (code)
            EXCEPT_SYSCALL:  excCodeOf = EXC_SYS;
            EXCEPT_RI:       excCodeOf = EXC_RI;
            EXCEPT_OVERFLOW: excCodeOf = EXC_OV;
            EXCEPT_TRAP:     excCodeOf = EXC_TR;
            default:         excCodeOf = EXC_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with the timer_int latch; only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_count_i,
    input  logic                  we_compare_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic [DATA_WIDTH-1:0] compare_o,
    output logic                  timer_int_o
);

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  timer_q, timer_d;

    // A Compare write acknowledges the timer and wins over a same-cycle match.
    always_comb begin
        count_d   = we_count_i ? wdata_i : count_q + 1'b1;
        compare_d = we_compare_i ? wdata_i : compare_q;
        timer_d   = timer_q;
        if (we_compare_i)
            timer_d = 1'b0;
        else if (count_q == compare_q)
            timer_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;

endmodule
`endif

// File: rtl/cp0.sv
// CP0 register file and exception arbiter. Define CP0_TIMER_EN to build Count/Compare
// and the timer interrupt; otherwise they read 0 and timer_int is tied low.
module cp0
    import cp0_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            hw_int,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  mem_valid,
    input  logic [2:0]            except_req,
    input  logic [ADDR_WIDTH-1:0] except_pc,
    input  logic                  except_bd,
    output logic [2:0]            exception,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  timer_int
);

    logic                  ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
    logic [7:0]            im_q, im_d, ip_q, ip_d;
    logic [4:0]            exc_q, exc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] count, compare;
    logic                  int_pending;

`ifdef CP0_TIMER_EN
    cp0_timer #(.DATA_WIDTH(DATA_WIDTH)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_count_i   (we && waddr == REG_COUNT),
        .we_compare_i (we && waddr == REG_COMPARE),
        .wdata_i      (wdata),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata[DATA_WIDTH-1:16];
    assign count        = '0;
    assign compare      = '0;
    assign timer_int    = 1'b0;
`endif

    assign int_pending = ie_q && !exl_q && |(ip_q & im_q);

    always_comb begin
        if (!mem_valid)
            exception = EXCEPT_NONE;
        else if (int_pending)
            exception = EXCEPT_INTERRUPT;
        else
            exception = except_req;
    end

    assign epc = (we && waddr == REG_EPC) ? wdata[ADDR_WIDTH-1:0] : epc_q;

    // MTC0 is applied first so that exception-owned fields overwrite it below.
    always_comb begin
        ie_d  = ie_q;
        exl_d = exl_q;
        im_d  = im_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = {hw_int[5] | timer_int, hw_int[4:0], ip_q[1:0]};
        if (we) begin
            case (waddr)
                REG_STATUS: begin
                    ie_d  = wdata[STATUS_IE];
                    exl_d = wdata[STATUS_EXL];
                    im_d  = wdata[STATUS_IM_LO +: 8];
                end
                REG_CAUSE: ip_d[1:0] = wdata[CAUSE_IP_LO +: 2];
                REG_EPC:   epc_d     = wdata[ADDR_WIDTH-1:0];
                default:   ;
            endcase
        end
        if (exception == EXCEPT_ERET) begin
            exl_d = 1'b0;
        end else if (exception != EXCEPT_NONE) begin
            exl_d = 1'b1;
            bd_d  = except_bd;
            exc_d = excCodeOf(exception);
            epc_d = except_bd ? except_pc - ADDR_WIDTH'(4) : except_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            im_q  <= '0;
            ip_q  <= '0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            ie_q  <= ie_d;
            exl_q <= exl_d;
            im_q  <= im_d;
            ip_q  <= ip_d;
            bd_q  <= bd_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_STATUS: begin
                rdata[STATUS_IE]         = ie_q;
                rdata[STATUS_EXL]        = exl_q;
                rdata[STATUS_IM_LO +: 8] = im_q;
            end
            REG_CAUSE: begin
                rdata[CAUSE_EXC_LO +: 5] = exc_q;
                rdata[CAUSE_IP_LO +: 8]  = ip_q;
                rdata[CAUSE_BD]          = bd_q;
            end
            REG_EPC:     rdata[ADDR_WIDTH-1:0] = epc_q;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios then random cycles against a field-level model.
module tb_cp0;

    localparam logic [2:0] X_NONE = 3'd0, X_INT = 3'd1, X_SYS = 3'd2, X_RI = 3'd3,
                           X_OV = 3'd4, X_TR = 3'd5, X_ERET = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        mem_valid;
    logic [2:0]  except_req;
    logic [15:0] except_pc;
    logic        except_bd;
    logic [2:0]  exception;
    logic [15:0] epc;
    logic        timer_int;

    int errors = 0;
    int checks = 0;

    // Model state, kept as plain fields
    int unsigned mIe, mExl, mIm, mIp, mExc, mBd, mEpc, mCount, mCompare, mTimer;
    logic [31:0] lastRdata;
    logic [2:0]  lastExc;
    logic [15:0] lastEpc;
    logic        lastTimer;

    cp0 dut (
        .clk(clk), .rst_n(rst_n), .hw_int(hw_int), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .mem_valid(mem_valid), .except_req(except_req),
        .except_pc(except_pc), .except_bd(except_bd), .exception(exception), .epc(epc),
        .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned excCodeFor(input logic [2:0] c);
        case (c)
            X_SYS:   return 8;
            X_RI:    return 10;
            X_OV:    return 12;
            X_TR:    return 13;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
`ifdef CP0_TIMER_EN
            5'd9:  return mCount;
            5'd11: return mCompare;
`endif
            5'd12: return (mIm << 8) | (mExl << 1) | mIe;
            5'd13: return (mBd << 31) | (mIp << 8) | (mExc << 2);
            5'd14: return mEpc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mIe = 0; mExl = 0; mIm = 0; mIp = 0; mExc = 0; mBd = 0; mEpc = 0;
        mCount = 0; mCompare = 0; mTimer = 0;
    endtask

    // One cycle: drive, check combinational outputs, advance model, pass the edge.
    task automatic applyStimulus(input logic rstN, input logic [5:0] hw, input logic weI,
                                 input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra,
                                 input logic mv, input logic [2:0] req, input logic [15:0] pc,
                                 input logic bd, input bit doCheck);
        logic [2:0]  expExc;
        logic [15:0] expEpc;
        int unsigned nIp, nCount, nTimer;
        rst_n = rstN; hw_int = hw; we = weI; waddr = wa; wdata = wd; raddr = ra;
        mem_valid = mv; except_req = req; except_pc = pc; except_bd = bd;
        #1;
        lastRdata = rdata; lastExc = exception; lastEpc = epc; lastTimer = timer_int;
        if (!mv) expExc = X_NONE;
        else if (mIe != 0 && mExl == 0 && (mIp & mIm) != 0) expExc = X_INT;
        else expExc = req;
        expEpc = (weI && wa == 5'd14) ? wd[15:0] : mEpc[15:0];
        if (doCheck) begin
            checkVal("exception", {29'b0, exception}, {29'b0, expExc});
            checkVal("epc", {16'b0, epc}, {16'b0, expEpc});
            checkVal($sformatf("rdata[%0d]", ra), rdata, modelRead(ra));
            checkVal("timer_int", {31'b0, timer_int}, mTimer);
        end
        if (!rstN) begin
            modelReset();
        end else begin
            nIp = mIp & 3;
            nCount = mCount + 1;
            nTimer = (mCount == mCompare) ? 1 : mTimer;
            if (weI) begin
                if (wa == 5'd12) begin
                    mIe = wd[0]; mExl = wd[1]; mIm = wd[15:8];
                end
                if (wa == 5'd13) nIp = wd[9:8];
                if (wa == 5'd14) mEpc = wd[15:0];
                if (wa == 5'd9) nCount = wd;
                if (wa == 5'd11) begin
                    mCompare = wd; nTimer = 0;
                end
            end
            nIp = nIp | (hw[4:0] << 2) | (((hw[5] | mTimer[0]) ? 1 : 0) << 7);
            mIp = nIp;
            if (expExc == X_ERET) begin
                mExl = 0;
            end else if (expExc != X_NONE) begin
                mExl = 1; mBd = bd; mExc = excCodeFor(expExc);
                mEpc = (bd ? pc - 16'd4 : pc) & 32'hFFFF;
            end
`ifdef CP0_TIMER_EN
            mCount = nCount; mTimer = nTimer;
`else
            mCount = 0; mCompare = 0; mTimer = 0;
`endif
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra);
        applyStimulus(1'b1, 6'd0, 1'b0, 5'd0, 32'd0, ra, 1'b0, X_NONE, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        applyStimulus(1'b1, 6'd0, 1'b1, wa, wd, 5'd12, 1'b0, X_NONE, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkVal(tag, obs, exp);
    endtask

    initial begin
        logic [4:0] regList [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        modelReset();
        @(negedge clk);
        // Reset: two unchecked edges, then checked reads while still held in reset
        applyStimulus(1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0, X_NONE, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0, X_NONE, 16'd0, 1'b0, 1'b0);
        foreach (regList[i]) begin
            applyStimulus(1'b0, 6'd0, 1'b0, 5'd0, 32'd0, regList[i], 1'b0, X_NONE, 16'd0, 1'b0, 1'b1);
            checkOutput($sformatf("reset_read_%0d", regList[i]), lastRdata, 32'h0);
            checkOutput("reset_exception", {29'b0, lastExc}, {29'b0, X_NONE});
        end

        // Interrupt on hw_int[0] with IE and IM[2] set
        mtc0(5'd12, 32'h0000_0401);
        applyStimulus(1'b1, 6'b000001, 1'b0, 5'd0, 32'd0, 5'd13, 1'b1, X_NONE, 16'h0040, 1'b0, 1'b1);
        applyStimulus(1'b1, 6'b000001, 1'b0, 5'd0, 32'd0, 5'd13, 1'b1, X_NONE, 16'h0040, 1'b0, 1'b1);
        checkOutput("int_taken", {29'b0, lastExc}, {29'b0, X_INT});
        idle(5'd12);
        checkOutput("int_exl", lastRdata, 32'h0000_0403);
        idle(5'd14);
        checkOutput("int_epc", lastRdata, 32'h0000_0040);

        // Syscall in a delay slot, then ERET
        applyStimulus(1'b1, 6'd0, 1'b0, 5'd0, 32'd0, 5'd13, 1'b1, X_SYS, 16'h0104, 1'b1, 1'b1);
        idle(5'd14);
        checkOutput("sys_epc", lastRdata, 32'h0000_0100);
        idle(5'd13);
        checkOutput("sys_cause", lastRdata & 32'h8000_007C, 32'h8000_0020);
        applyStimulus(1'b1, 6'd0, 1'b0, 5'd0, 32'd0, 5'd12, 1'b1, X_ERET, 16'h0108, 1'b0, 1'b1);
        idle(5'd12);
        checkOutput("eret_exl", lastRdata, 32'h0000_0401);

        // Timer match and acknowledge
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 8; i++) idle(5'd9);
`ifdef CP0_TIMER_EN
        checkOutput("timer_set", {31'b0, lastTimer}, 32'd1);
        mtc0(5'd11, 32'd100);
        idle(5'd11);
        checkOutput("timer_clear", {31'b0, lastTimer}, 32'd0);
`else
        checkOutput("timer_off", {31'b0, lastTimer}, 32'd0);
`endif

        // Same-cycle MTC0 EPC and ERET: epc forwards the write
        applyStimulus(1'b1, 6'd0, 1'b1, 5'd14, 32'h0000_0200, 5'd14, 1'b1, X_ERET, 16'h0300, 1'b0, 1'b1);
        checkOutput("eret_fwd_epc", {16'b0, lastEpc}, 32'h0000_0200);

        // Pending interrupt with no valid instruction: nothing taken
        applyStimulus(1'b1, 6'b000001, 1'b0, 5'd0, 32'd0, 5'd13, 1'b0, X_NONE, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 6'b000001, 1'b0, 5'd0, 32'd0, 5'd13, 1'b0, X_OV, 16'h0500, 1'b0, 1'b1);
        checkOutput("bubble_none", {29'b0, lastExc}, {29'b0, X_NONE});
        idle(5'd14);
        checkOutput("bubble_epc", lastRdata, 32'h0000_0200);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa, ra;
            logic [31:0] wd;
            int sel;
            sel = $urandom_range(0, 6);
            wa = (sel < 5) ? regList[sel] : 5'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : regList[$urandom_range(0, 4)];
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) wd = wd & 32'h0000_FF03;
            applyStimulus(($urandom_range(0, 99) != 0), 6'($urandom) & 6'($urandom),
                          ($urandom_range(0, 2) == 0), wa, wd, ra,
                          ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 6)),
                          16'($urandom), 1'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
